iter_divider: RTL
=================

# iter_divider

Iterative restoring divider that produces one quotient bit per clock and sequences its iterations with an internal up-counter. It sits in the execute stage alongside the multiplier, inside the multdiv unit. It accepts a one-cycle start pulse from the pipeline control and raises a one-cycle ready strobe when the quotient is valid. The pipeline stalls on `busy` until that strobe.

## Interface
- `WIDTH`, default 32: operand and quotient width in bits.
- `CNT_W`, default 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.
- `clock`  in  1: single clock, rising-edge.
- `clr_n`  in  1: asynchronous, active-low reset.
- `ctrl_DIV`  in  1: start pulse. Operands are sampled on the rising edge where this is 1.
- `data_operandA`  in  WIDTH: dividend.
- `data_operandB`  in  WIDTH: divisor.
- `data_result`  out  WIDTH: quotient, registered. Held until the next completion.
- `data_exception`  out  1: divide-by-zero flag, registered. Valid with `data_resultRDY`.
- `data_resultRDY`  out  1: one-cycle strobe marking that the result is valid.
- `busy`  out  1: high while an operation is in flight (state RUN).

## Operation
- Reset (`clr_n`=0, asynchronous, any state) forces the following, effective immediately:
  - state IDLE, counter 0;
  - `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0;
  - internal remainder and quotient registers cleared.
  - Reset mid-operation abandons the operation; no strobe follows.
- States are IDLE, RUN and DONE.
- IDLE → RUN on `ctrl_DIV`=1 with divisor ≠ 0. The start edge latches:
  - divisor;
  - quotient register ← dividend;
  - remainder ← 0;
  - counter ← 0.
- IDLE → DONE on `ctrl_DIV`=1 with divisor = 0. Marks the exception path.
- RUN performs one iteration per edge:
  - {rem, quo} shifted left by 1;
  - trial = rem − divisor, computed at WIDTH+1 bits;
  - if trial ≥ 0: rem ← trial and quo[0] ← 1; otherwise quo[0] ← 0;
  - counter increments.
- RUN → DONE on the edge where counter = WIDTH−1; that edge performs the final iteration.
- DONE lasts one cycle:
  - `data_resultRDY`=1;
  - `data_result` = quotient, or 0 on the exception path;
  - `data_exception` = 1 only on the exception path;
  - next edge goes to IDLE.
- Restart: `ctrl_DIV`=1 in RUN or DONE aborts the current operation and restarts with the new operands exactly as from IDLE. An aborted operation never produces a strobe.
- `data_result` and `data_exception` hold their values after DONE until the next DONE or reset.
- The remainder is internal only and is not exported.

## Timing
- The start edge is E0.
- Normal path:
  - iterations occur on edges E1..E(WIDTH);
  - `data_resultRDY` is high for the single cycle after edge E(WIDTH);
  - latency from start to strobe is WIDTH+1 cycles (33 at the default).
- Zero-divisor path: `data_resultRDY`=1 and `data_exception`=1 in the cycle after E0, i.e. latency 1.
- `busy` is high in the cycles after E0 through E(WIDTH−1), and low in DONE and IDLE.
- Back-to-back: a start in the DONE cycle is legal. The strobe for the first operation is still visible in that cycle, and the new operation begins at that edge.
- Counter wrap never occurs; the counter is reloaded at every start.

## Configuration
- Macro: `ITER_DIVIDER_SIGNED_EN`.
- Defined: operands are two's complement.
  - Magnitudes of both operands are divided.
  - The quotient is negated when the operand signs differ; it truncates toward zero.
  - MIN/−1 returns MIN (0x80000000 at the default width) with `data_exception`=0.
  - Negation and magnitude logic adds no cycles; latency is unchanged.
- Undefined: operands and quotient are unsigned; no sign logic is compiled.

## Test plan
- Reset: hold `clr_n`=0 with `clock` running, release it, and wait with `ctrl_DIV`=0.
  - Required: all outputs stay 0 and state remains IDLE.
  - Assert `clr_n`=0 asynchronously mid-RUN: outputs clear at once and no strobe follows.
- Unsigned basic: A=100, B=7, start pulse.
  - Required: `busy`=1 for 32 cycles, then `data_resultRDY`=1 for exactly one cycle, 33 cycles after start.
  - `data_result`=14 and `data_exception`=0; result held afterwards.
- Divide by zero: A=0x12345678, B=0.
  - Required: next cycle `data_resultRDY`=1, `data_exception`=1, `data_result`=0; `busy` never asserts.
- Restart: start A=1000, B=3, then pulse `ctrl_DIV` again 10 cycles later with A=50, B=5.
  - Required: only one strobe, 33 cycles after the second pulse, with `data_result`=10.
- Edge values: A=0xFFFFFFFF, B=1 → 0xFFFFFFFF unsigned; A=5, B=9 → 0.
  - Then start in the DONE cycle: the second result arrives 33 cycles after that edge.
- Signed build (`ITER_DIVIDER_SIGNED_EN` defined):
  - −7/2 → 0xFFFFFFFD;
  - 7/−2 → 0xFFFFFFFD;
  - −8/−2 → 4;
  - 0x80000000/0xFFFFFFFF → 0x80000000 with `data_exception`=0.

Source files
------------

// File: rtl/iter_divider.sv
// ---------------------------------------------------------------------------
// iter_divider
//
// Iterative restoring divider for the execute-stage multdiv unit. It produces
// one quotient bit per clock, sequenced by an internal up-counter. A one-cycle
// start pulse launches an operation. A one-cycle ready strobe marks a valid
// quotient. The pipeline stalls on busy until that strobe.
//
// Optional feature macro: ITER_DIVIDER_SIGNED_EN
//   undefined : unsigned operands and quotient (default build)
//   defined   : two's-complement operands, quotient truncated toward zero.
//               Latency is the same in both builds.
//
// Parameters
//   WIDTH  operand / quotient width (default 32)
//   CNT_W  iteration counter width, 2**CNT_W > WIDTH (default 6)
//
// Ports
//   clock           in   rising-edge clock
//   clr_n           in   asynchronous active-low reset
//   ctrl_DIV        in   start pulse; operands sampled on that edge
//   data_operandA   in   dividend
//   data_operandB   in   divisor
//   data_result     out  registered quotient, held until next completion
//   data_exception  out  registered divide-by-zero flag, valid with RDY
//   data_resultRDY  out  one-cycle result-valid strobe
//   busy            out  high while an operation is in flight (RUN)
// ---------------------------------------------------------------------------
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] div_q;   // latched divisor (magnitude in signed build)
  logic [WIDTH-1:0] quo_q;   // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] rem_q;   // partial remainder, internal only
  logic [CNT_W-1:0] cnt_q;

  // Operand conditioning at the start edge.
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             div_zero;

`ifdef ITER_DIVIDER_SIGNED_EN
  logic neg_q;       // quotient must be negated on completion
  logic neg_start;

  // The magnitude of MIN is MIN itself. Read as unsigned, that is the correct
  // magnitude, so MIN/-1 works out to MIN with no special case.
  always_comb begin
    mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    neg_start = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
  end
`else
  always_comb begin
    mag_a = data_operandA;
    mag_b = data_operandB;
  end
`endif

  assign div_zero = (data_operandB == '0);

  // One restoring iteration. The shifted remainder needs WIDTH+1 bits, because
  // a divisor above 2**(WIDTH-1) can leave a remainder whose doubled value
  // overflows WIDTH bits.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] quo_final;

  // NOTE: every always_comb output gets a default assignment first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, div_q};
    rem_nxt = rem_sh[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

`ifdef ITER_DIVIDER_SIGNED_EN
  assign quo_final = neg_q ? -quo_nxt : quo_nxt;
`else
  assign quo_final = quo_nxt;
`endif

  logic last_iter;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples its pre-edge value, whatever order the statements appear in.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state          <= IDLE;
      div_q          <= '0;
      quo_q          <= '0;
      rem_q          <= '0;
      cnt_q          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
`ifdef ITER_DIVIDER_SIGNED_EN
      neg_q          <= 1'b0;
`endif
    end else begin
      data_resultRDY <= 1'b0;

      if (ctrl_DIV) begin
        // A start in any state, RUN and DONE included, abandons the current
        // operation and reloads everything.
        div_q <= mag_b;
        quo_q <= mag_a;
        rem_q <= '0;
        cnt_q <= '0;
`ifdef ITER_DIVIDER_SIGNED_EN
        neg_q <= neg_start;
`endif
        if (div_zero) begin
          state          <= DONE;
          busy           <= 1'b0;
          data_resultRDY <= 1'b1;
          data_exception <= 1'b1;
          data_result    <= '0;
        end else begin
          state <= RUN;
          busy  <= 1'b1;
        end
      end else begin
        unique case (state)
          RUN: begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
              state          <= DONE;
              busy           <= 1'b0;
              data_resultRDY <= 1'b1;
              data_exception <= 1'b0;
              data_result    <= quo_final;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
